// File: rtl/spi_cmd_pkg.sv
// rtl/spi_cmd_pkg.sv - frame/response field layout, FSM states and constants for spi_cmd_bridge
package spi_cmd_pkg;

  localparam int RW_BIT    = 15;
  localparam int ADDR_MSB  = 14;
  localparam int ADDR_LSB  = 8;
  localparam int WDATA_MSB = 7;
  localparam int WDATA_LSB = 0;

  localparam logic [6:0] STATUS_ADDR   = 7'h00;
  localparam logic [7:0] TIMEOUT_RDATA = 8'hFF;

  localparam int RESP_VALID_BIT = 15;
  localparam int RESP_ERR_BIT   = 14;
  localparam int RESP_SEQ_MSB   = 13;
  localparam int RESP_SEQ_LSB   = 8;
  localparam int RESP_RDATA_MSB = 7;
  localparam int RESP_RDATA_LSB = 0;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WR   = 2'd1;
  localparam logic [1:0] ST_RD   = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    WR   = ST_WR,
    RD   = ST_RD,
    RESP = ST_RESP
  } fsm_state_e;

  // Bit 15 is only ever 0 out of reset, so every packed response carries it set.
  function automatic logic [15:0] pack_resp(input logic err, input logic [5:0] seq,
                                            input logic [7:0] rdata);
    logic [15:0] w;
    w = '0;
    w[RESP_VALID_BIT] = 1'b1;
    w[RESP_ERR_BIT] = err;
    w[RESP_SEQ_MSB:RESP_SEQ_LSB] = seq;
    w[RESP_RDATA_MSB:RESP_RDATA_LSB] = rdata;
    return w;
  endfunction

endpackage

// File: rtl/spi_cmd_timeout.sv
// rtl/spi_cmd_timeout.sv - loadable down-counter; expired while the count sits at zero
module spi_cmd_timeout #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             expired
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_val;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == '0);

endmodule

// File: rtl/spi_cmd_bridge.sv
// rtl/spi_cmd_bridge.sv - SPI frame to register-bus bridge with one-frame-late response word
// Build option: SPI_CMD_WR_ECHO_EN returns the written byte in the write response rdata field.
module spi_cmd_bridge
  import spi_cmd_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int ADDR_WIDTH     = 7,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] rxd_data,
  input  logic                  flag_done,
  output logic [DATA_WIDTH-1:0] txd_data,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [7:0]            bus_wdata,
  output logic                  bus_we,
  output logic                  bus_re,
  input  logic [7:0]            bus_rdata,
  input  logic                  bus_ack,
  output logic                  busy
);

  localparam logic [7:0] TMO_LOAD = 8'(TIMEOUT_CYCLES - 1);

  fsm_state_e state_q, state_d;
  logic [5:0]            seq_q, seq_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            wdata_q, wdata_d;
  logic [7:0]            rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  ovr_q, ovr_d;
  logic                  tmo_q, tmo_d;
  logic [DATA_WIDTH-1:0] txd_q, txd_d;

  logic                  frame_rw;
  logic [ADDR_WIDTH-1:0] frame_addr;
  logic [7:0]            frame_wdata;
  logic [7:0]            wr_resp_rdata;
  logic [5:0]            seq_inc;
  logic                  tmo_load, tmo_set, flags_clr, tmo_expired;

  assign frame_rw    = rxd_data[RW_BIT];
  assign frame_addr  = rxd_data[ADDR_MSB:ADDR_LSB];
  assign frame_wdata = rxd_data[WDATA_MSB:WDATA_LSB];
  assign seq_inc     = seq_q + 6'd1;

`ifdef SPI_CMD_WR_ECHO_EN
  assign wr_resp_rdata = frame_wdata;
`else
  assign wr_resp_rdata = 8'h00;
`endif

  spi_cmd_timeout #(.CNT_W(8)) u_timeout (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (state_q == RESP),
    .load     (tmo_load),
    .load_val (TMO_LOAD),
    .en       ((state_q == WR) || (state_q == RD)),
    .expired  (tmo_expired)
  );

  always_comb begin
    state_d   = state_q;
    seq_d     = seq_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    txd_d     = txd_q;
    tmo_load  = 1'b0;
    tmo_set   = 1'b0;
    flags_clr = 1'b0;

    case (state_q)
      IDLE: begin
        if (flag_done) begin
          seq_d   = seq_inc;
          addr_d  = frame_addr;
          wdata_d = frame_wdata;
          err_d   = 1'b0;
          if (frame_rw) begin
            state_d  = WR;
            rdata_d  = wr_resp_rdata;
            tmo_load = 1'b1;
          end else if (frame_addr != STATUS_ADDR) begin
            state_d  = RD;
            tmo_load = 1'b1;
          end else begin
            // Status snapshot already reflects this frame's sequence number.
            state_d   = RESP;
            rdata_d   = {ovr_q, tmo_q, seq_inc};
            flags_clr = 1'b1;
          end
        end
      end
      WR: begin
        if (bus_ack) begin
          state_d = RESP;
        end else if (tmo_expired) begin
          state_d = RESP;
          err_d   = 1'b1;
          tmo_set = 1'b1;
        end
      end
      RD: begin
        if (bus_ack) begin
          state_d = RESP;
          rdata_d = bus_rdata;
        end else if (tmo_expired) begin
          state_d = RESP;
          rdata_d = TIMEOUT_RDATA;
          err_d   = 1'b1;
          tmo_set = 1'b1;
        end
      end
      RESP: begin
        txd_d   = pack_resp(err_q, seq_q, rdata_q);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A new event in the capture cycle keeps the sticky flag set.
    ovr_d = (ovr_q & ~flags_clr) | (flag_done & (state_q != IDLE));
    tmo_d = (tmo_q & ~flags_clr) | tmo_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      seq_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      ovr_q   <= 1'b0;
      tmo_q   <= 1'b0;
      txd_q   <= '0;
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      ovr_q   <= ovr_d;
      tmo_q   <= tmo_d;
      txd_q   <= txd_d;
    end
  end

  assign txd_data  = txd_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign bus_we    = (state_q == WR);
  assign bus_re    = (state_q == RD);
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_spi_cmd_bridge.sv
// tb/tb_spi_cmd_bridge.sv - self-checking bench for spi_cmd_bridge (table vectors plus scoreboard)
module tb_spi_cmd_bridge;

  localparam int T = 64;
`ifdef SPI_CMD_WR_ECHO_EN
  localparam bit ECHO = 1'b1;
`else
  localparam bit ECHO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] rxd_data = '0;
  logic        flag_done = 1'b0;
  logic [15:0] txd_data;
  logic [6:0]  bus_addr;
  logic [7:0]  bus_wdata;
  logic        bus_we, bus_re, busy;
  logic [7:0]  bus_rdata = '0;
  logic        bus_ack = 1'b0;

  spi_cmd_bridge #(.DATA_WIDTH(16), .ADDR_WIDTH(7), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n), .rxd_data(rxd_data), .flag_done(flag_done),
    .txd_data(txd_data), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_we(bus_we), .bus_re(bus_re), .bus_rdata(bus_rdata), .bus_ack(bus_ack), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  typedef struct {
    logic [15:0] txd;
    int          start;
    int          lat;
  } resp_t;
  resp_t sb[$];

  typedef struct {
    logic [15:0] frame;
    int          dly;
    logic        no_ack;
    logic [7:0]  rdata;
    logic [7:0]  exp_rd;
    logic        exp_err;
  } vec_t;
  vec_t tbl[12];

  logic [5:0] seq_m = '0;
  logic       ovr_m = 1'b0;
  logic       tmo_m = 1'b0;

  int         cfg_dly = 0;
  logic       cfg_no_ack = 1'b0;
  logic [7:0] cfg_rdata = '0;
  logic       exp_we = 1'b0, exp_re = 1'b0;
  logic [6:0] exp_addr = '0;
  logic [7:0] exp_wdata = '0;
  int         exp_len = 0;
  int         scnt = 0;

  // Register-bus responder: acks after cfg_dly strobe cycles, checks strobe contents and length.
  always @(negedge clk) begin
    bus_ack = 1'b0;
    if (!rst_n) begin
      scnt = 0;
    end else if (bus_we || bus_re) begin
      if (scnt == 0) begin
        check("strobe_kind", {bus_we, bus_re}, {exp_we, exp_re});
        check("bus_addr", bus_addr, exp_addr);
        if (bus_we) check("bus_wdata", bus_wdata, exp_wdata);
      end
      if (!cfg_no_ack && scnt == cfg_dly) begin
        bus_ack   = 1'b1;
        bus_rdata = cfg_rdata;
      end
      scnt++;
    end else if (scnt != 0) begin
      check("strobe_len", scnt, exp_len);
      scnt = 0;
    end
  end

  // Response monitor: txd_data is fresh in the first cycle busy is low again.
  logic prev_busy = 1'b0;
  always @(negedge clk) begin
    resp_t r;
    if (rst_n && prev_busy && !busy) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_resp: got txd %0h, expected no response", txd_data);
      end else begin
        r = sb.pop_front();
        check("txd_data", txd_data, r.txd);
        check("latency", cyc - r.start, r.lat);
      end
    end
    prev_busy = busy;
  end

  task automatic issue(input logic [15:0] frame);
    rxd_data  = frame;
    flag_done = 1'b1;
    @(negedge clk);
    rxd_data  = '0;
    flag_done = 1'b0;
  endtask

  task automatic start(input logic [15:0] frame, input int dly, input logic no_ack,
                       input logic [7:0] rdata, input logic [7:0] exp_rd, input logic exp_err);
    logic       is_wr, is_stat;
    logic [6:0] a;
    resp_t      r;
    is_wr   = frame[15];
    a       = frame[14:8];
    is_stat = !is_wr && (a == 7'h00);
    seq_m   = seq_m + 6'd1;
    if (is_stat) begin
      ovr_m = 1'b0;
      tmo_m = 1'b0;
    end else if (no_ack) begin
      tmo_m = 1'b1;
    end
    cfg_dly    = dly;
    cfg_no_ack = no_ack;
    cfg_rdata  = rdata;
    exp_we     = is_wr;
    exp_re     = !is_wr && !is_stat;
    exp_addr   = a;
    exp_wdata  = frame[7:0];
    exp_len    = no_ack ? T : dly + 1;
    r.txd   = {1'b1, exp_err, seq_m, exp_rd};
    r.start = cyc;
    r.lat   = is_stat ? 2 : (no_ack ? T + 2 : dly + 3);
    sb.push_back(r);
    issue(frame);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_idle: busy still 1 after %0d cycles, expected 0", n);
    end
  endtask

  function automatic logic [7:0] status_exp();
    return {ovr_m, tmo_m, seq_m + 6'd1};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at cycle %0d, expected finish", cyc);
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{16'h9A3C, 0,  1'b0, 8'h00, (ECHO ? 8'h3C : 8'h00), 1'b0};
    tbl[1]  = '{16'h1A00, 0,  1'b0, 8'h5E, 8'h5E, 1'b0};
    tbl[2]  = '{16'hB7FF, 2,  1'b0, 8'h00, (ECHO ? 8'hFF : 8'h00), 1'b0};
    tbl[3]  = '{16'h0500, 0,  1'b1, 8'h00, 8'hFF, 1'b1};
    tbl[4]  = '{16'h0000, 0,  1'b0, 8'h00, 8'h45, 1'b0};
    tbl[5]  = '{16'h0000, 0,  1'b0, 8'h00, 8'h06, 1'b0};
    tbl[6]  = '{16'h7F00, 3,  1'b0, 8'hA5, 8'hA5, 1'b0};
    tbl[7]  = '{16'h8000, 1,  1'b0, 8'h00, 8'h00, 1'b0};
    tbl[8]  = '{16'h8155, 0,  1'b1, 8'h00, (ECHO ? 8'h55 : 8'h00), 1'b1};
    tbl[9]  = '{16'h00AB, 0,  1'b0, 8'h00, 8'h4A, 1'b0};
    tbl[10] = '{16'h0300, 63, 1'b0, 8'h3C, 8'h3C, 1'b0};
    tbl[11] = '{16'h0000, 0,  1'b0, 8'h00, 8'h0C, 1'b0};

    #1 rst_n = 1'b0;
    #1;
    check("reset_txd", txd_data, 16'h0000);
    check("reset_bus", {bus_addr, bus_wdata, bus_we, bus_re, busy}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      start(tbl[i].frame, tbl[i].dly, tbl[i].no_ack, tbl[i].rdata, tbl[i].exp_rd, tbl[i].exp_err);
      wait_idle();
    end

    // Overrun: second frame arrives mid-read and must be dropped without side effects.
    start(16'h2200, 5, 1'b0, 8'h11, 8'h11, 1'b0);
    issue(16'h9999);
    ovr_m = 1'b1;
    wait_idle();
    start(16'h0000, 0, 1'b0, 8'h00, status_exp(), 1'b0);
    wait_idle();

    // Back-to-back status reads walk the sequence field through its wrap.
    for (int i = 0; i < 64; i++) begin
      start(16'h0000, 0, 1'b0, 8'h00, status_exp(), 1'b0);
      wait_idle();
    end

    // Reset in the middle of a read that never gets acked.
    start(16'h0500, 0, 1'b1, 8'h00, 8'hFF, 1'b1);
    repeat (3) @(negedge clk);
    check("re_before_reset", bus_re, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_txd", txd_data, 16'h0000);
    check("midrst_bus", {bus_addr, bus_wdata, bus_we, bus_re, busy}, 0);
    sb.delete();
    seq_m = '0;
    ovr_m = 1'b0;
    tmo_m = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start(16'h0000, 0, 1'b0, 8'h00, status_exp(), 1'b0);
    wait_idle();
    start(16'h9A3C, 1, 1'b0, 8'h00, (ECHO ? 8'h3C : 8'h00), 1'b0);
    wait_idle();
    repeat (3) @(negedge clk);

    check("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
